// File: rtl/game_round_controller_pkg.sv
// Shared encodings for the fight datapath: actions, winner codes, controller states.
// Also carries the end-of-turn winner decision so the player side can reuse it.
// Pure declarations; no clocked logic.
package game_round_controller_pkg;

  // Action encodings, shared with firstPlayer/secondPlayer
  localparam logic [2:0] ACT_KICK   = 3'b000;
  localparam logic [2:0] ACT_PUNCH  = 3'b001;
  localparam logic [2:0] ACT_AWAIT  = 3'b010;
  localparam logic [2:0] ACT_JUMP   = 3'b011;
  localparam logic [2:0] ACT_LEFT1  = 3'b100;
  localparam logic [2:0] ACT_LEFT2  = 3'b101;
  localparam logic [2:0] ACT_RIGHT1 = 3'b110;
  localparam logic [2:0] ACT_RIGHT2 = 3'b111;

  // Winner encodings
  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  // Controller state encodings
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_COLLECT = 3'd1;
  localparam logic [2:0] ST_APPLY   = 3'd2;
  localparam logic [2:0] ST_SETTLE  = 3'd3;
  localparam logic [2:0] ST_CHECK   = 3'd4;
  localparam logic [2:0] ST_OVER    = 3'd5;

  // Knockouts take precedence; on the last turn the game is decided on points.
  function automatic logic [1:0] decide_winner(input logic [1:0] h1,
                                               input logic [1:0] h2,
                                               input logic       last_turn);
    logic [1:0] w;
    w = WIN_NONE;
    if (h1 == 2'd0 && h2 == 2'd0) w = WIN_DRAW;
    else if (h1 == 2'd0)          w = WIN_P2;
    else if (h2 == 2'd0)          w = WIN_P1;
    else if (last_turn) begin
      if (h1 > h2)      w = WIN_P1;
      else if (h2 > h1) w = WIN_P2;
      else              w = WIN_DRAW;
    end
    return w;
  endfunction

endpackage

// File: rtl/game_round_controller_turn_timer.sv
// Turn timer: TW-bit up-counter with synchronous clear and count enable.
// expire_o is combinational and high on the enabled cycle where count == TURN_TIMEOUT-1.
// No backpressure; the controller clears it whenever it is outside COLLECT.
module game_round_controller_turn_timer #(
  parameter int TURN_TIMEOUT = 100,
  parameter int TW           = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  logic [TW-1:0] cnt_q;

  // Count cycles spent collecting; clear has priority over enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (en_i)  cnt_q <= cnt_q + 1'b1;
  end

  assign expire_o = en_i && (cnt_q == TW'(TURN_TIMEOUT - 1));

endmodule

// File: rtl/game_round_controller.sv
// Turn sequencer: collects one action per player (timeout defaults to await), pulses
// actionEnable once, then samples health two cycles later and decides the winner.
// Strobe -> actionEnable is 1 cycle minimum; OVER is sticky until reset.
module game_round_controller
  import game_round_controller_pkg::*;
#(
  parameter int TURN_TIMEOUT = 100,
  parameter int MAX_TURNS    = 15,
  parameter int TW           = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       act_valid1,
  input  logic [2:0] action1_in,
  input  logic       act_valid2,
  input  logic [2:0] action2_in,
  input  logic [1:0] health1,
  input  logic [1:0] health2,
  output logic [2:0] action1,
  output logic [2:0] action2,
  output logic       actionEnable,
  output logic       isGameOver,
  output logic [1:0] winner,
  output logic [3:0] turn_count,
  output logic       timeout
);

  localparam logic [3:0] MAX_T4 = 4'(MAX_TURNS);

  logic [2:0] state_q, state_d;
  logic [2:0] act1_q, act1_d;
  logic [2:0] act2_q, act2_d;
  logic       lat1_q, lat1_d;
  logic       lat2_q, lat2_d;
  logic       over_q, over_d;
  logic [1:0] win_q, win_d;
  logic [3:0] tc_q, tc_d;
  logic       timeout_c;
  logic       expire;
  logic [1:0] check_win;

  game_round_controller_turn_timer #(
    .TURN_TIMEOUT(TURN_TIMEOUT),
    .TW          (TW)
  ) u_timer (
    .clk     (clk),
    .rst_n   (reset),
    .clr_i   (state_q != ST_COLLECT),
    .en_i    (state_q == ST_COLLECT),
    .expire_o(expire)
  );

  assign check_win = decide_winner(health1, health2, (tc_q + 4'd1) == MAX_T4);

  // Next-state and datapath decisions for the turn sequence
  always_comb begin
    state_d   = state_q;
    act1_d    = act1_q;
    act2_d    = act2_q;
    lat1_d    = lat1_q;
    lat2_d    = lat2_q;
    over_d    = over_q;
    win_d     = win_q;
    tc_d      = tc_q;
    timeout_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_COLLECT;
      end
      ST_COLLECT: begin
        // Only the first strobe of a turn counts for each player
        if (act_valid1 && !lat1_q) begin
          act1_d = action1_in;
          lat1_d = 1'b1;
        end
        if (act_valid2 && !lat2_q) begin
          act2_d = action2_in;
          lat2_d = 1'b1;
        end
        if (lat1_d && lat2_d) begin
          state_d = ST_APPLY;
        end else if (expire) begin
          // A strobe on the expiry cycle already set latN_d, so it beats the default
          if (!lat1_d) act1_d = ACT_AWAIT;
          if (!lat2_d) act2_d = ACT_AWAIT;
          timeout_c = 1'b1;
          state_d   = ST_APPLY;
        end
      end
      ST_APPLY:  state_d = ST_SETTLE;
      ST_SETTLE: state_d = ST_CHECK;
      ST_CHECK: begin
        lat1_d = 1'b0;
        lat2_d = 1'b0;
        if (tc_q != MAX_T4) tc_d = tc_q + 4'd1;
        if (check_win != WIN_NONE) begin
          win_d   = check_win;
          over_d  = 1'b1;
          state_d = ST_OVER;
        end else begin
          state_d = ST_COLLECT;
        end
      end
      ST_OVER: state_d = ST_OVER;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset aborts any turn in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      act1_q  <= ACT_AWAIT;
      act2_q  <= ACT_AWAIT;
      lat1_q  <= 1'b0;
      lat2_q  <= 1'b0;
      over_q  <= 1'b0;
      win_q   <= WIN_NONE;
      tc_q    <= 4'd0;
    end else begin
      state_q <= state_d;
      act1_q  <= act1_d;
      act2_q  <= act2_d;
      lat1_q  <= lat1_d;
      lat2_q  <= lat2_d;
      over_q  <= over_d;
      win_q   <= win_d;
      tc_q    <= tc_d;
    end
  end

  assign action1      = act1_q;
  assign action2      = act2_q;
  assign actionEnable = (state_q == ST_APPLY);
  assign isGameOver   = over_q;
  assign winner       = win_q;
  assign turn_count   = tc_q;
  assign timeout      = timeout_c;

endmodule
